// File: rtl/prach_fft_shift_pkg.sv
// Shared types for the PRACH FFT-shift stage: default geometry, sample layout
// and the write/read state encodings.
package prach_fft_shift_pkg;

   localparam int N_FFT_DEFAULT = 1024;
   localparam int DW_DEFAULT    = 16;
   localparam int CCW_DEFAULT   = 3;

   localparam int ADDR_W = $clog2(N_FFT_DEFAULT);
   localparam int HALF   = N_FFT_DEFAULT / 2;

   typedef struct packed {
      logic signed [DW_DEFAULT-1:0] i;
      logic signed [DW_DEFAULT-1:0] q;
   } sample_t;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_FILL = 2'd1,
      W_DROP = 2'd2
   } wstate_t;

   typedef enum logic {
      R_IDLE  = 1'b0,
      R_DRAIN = 1'b1
   } rstate_t;

endpackage

// File: rtl/prach_fft_shift_bank_ram.sv
// Two-bank frame store: simple dual-port RAM with one write port and a
// registered read port (one cycle latency).
module prach_fft_shift_bank_ram #(
   parameter int DEPTH = 2048,
   parameter int AW    = 11,
   parameter int W     = 32
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/prach_fft_shift_reorder.sv
// Streaming FFT-shift for the short-format PRACH path: ping-pong frame buffer,
// natural-order bins in, DC-centred order out, carrier tag carried per frame.
module prach_fft_shift_reorder
   import prach_fft_shift_pkg::*;
#(
   parameter int N_FFT = 2 * HALF,
   parameter int DW    = DW_DEFAULT,
   parameter int CCW   = CCW_DEFAULT
) (
   input  logic                 clk,
   input  logic                 areset_n,
   input  logic                 in_valid,
   input  logic                 in_sop,
   input  logic                 in_eop,
   input  logic signed [DW-1:0] in_i,
   input  logic signed [DW-1:0] in_q,
   input  logic [CCW-1:0]       in_cc,
   input  logic                 out_ready,
   output logic                 out_valid,
   output logic                 out_sop,
   output logic                 out_eop,
   output logic signed [DW-1:0] out_i,
   output logic signed [DW-1:0] out_q,
   output logic [CCW-1:0]       out_cc,
   input  logic                 err_clr,
   output logic                 overflow,
   output logic                 frame_err
);

   localparam int            AB       = $clog2(N_FFT);
   localparam logic [AB-1:0] LAST_BIN = AB'(N_FFT - 1);
   localparam logic [AB-1:0] MSB_FLIP = AB'(N_FFT / 2);

   typedef struct packed {
      logic                 sop;
      logic                 eop;
      logic [CCW-1:0]       cc;
      logic signed [DW-1:0] i;
      logic signed [DW-1:0] q;
   } beat_t;

   // bank bookkeeping shared by both sides
   logic           wbank, rbank;
   logic [1:0]     bank_full;
   logic [CCW-1:0] bank_cc [2];
   logic           free_now;

   // write side
   wstate_t        wstate, wstate_nx;
   logic [AB-1:0]  wcnt;
   logic [AB:0]    waddr;
   logic           sop_v, wbank_free;
   logic           we, restart, wcnt_inc, commit, err_ev, ovf_ev;

   assign sop_v      = in_valid & in_sop;
   assign wbank_free = !bank_full[wbank] || (free_now && (rbank == wbank));

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) wstate <= W_IDLE;
      else           wstate <= wstate_nx;
   end

   always_comb begin
      wstate_nx = wstate;
      case (wstate)
         W_IDLE: if (sop_v) wstate_nx = wbank_free ? W_FILL : W_DROP;
         W_FILL: if (in_valid && !in_sop && (in_eop || wcnt == LAST_BIN)) wstate_nx = W_IDLE;
         W_DROP: begin
            if (sop_v)                  wstate_nx = wbank_free ? W_FILL : W_DROP;
            else if (in_valid && in_eop) wstate_nx = W_IDLE;
         end
         default: wstate_nx = W_IDLE;
      endcase
   end

   always_comb begin
      we       = 1'b0;
      waddr    = {wbank, wcnt};
      restart  = 1'b0;
      wcnt_inc = 1'b0;
      commit   = 1'b0;
      err_ev   = 1'b0;
      ovf_ev   = 1'b0;
      case (wstate)
         W_IDLE, W_DROP: begin
            if (sop_v) begin
               if (wbank_free) begin
                  we      = 1'b1;
                  waddr   = {wbank, {AB{1'b0}}};
                  restart = 1'b1;
               end else begin
                  ovf_ev  = 1'b1;
               end
            end else if (in_valid && wstate == W_IDLE) begin
               err_ev = 1'b1;
            end
         end
         W_FILL: begin
            if (in_valid) begin
               we = 1'b1;
               if (in_sop) begin
                  // a mid-frame sop throws away the partial frame and restarts it
                  waddr   = {wbank, {AB{1'b0}}};
                  restart = 1'b1;
                  err_ev  = 1'b1;
               end else if (wcnt == LAST_BIN) begin
                  commit = in_eop;
                  err_ev = !in_eop;
               end else if (in_eop) begin
                  err_ev = 1'b1;
               end else begin
                  wcnt_inc = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         wbank      <= 1'b0;
         wcnt       <= '0;
         bank_cc[0] <= '0;
         bank_cc[1] <= '0;
      end else begin
         if (restart) begin
            wcnt           <= AB'(1);
            bank_cc[wbank] <= in_cc;
         end else if (wcnt_inc) begin
            wcnt <= wcnt + 1'b1;
         end else if (wstate_nx == W_IDLE) begin
            wcnt <= '0;
         end
         if (commit) wbank <= ~wbank;
      end
   end

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         bank_full <= 2'b00;
      end else begin
         for (int b = 0; b < 2; b++) begin
            if (commit && wbank == 1'(b))        bank_full[b] <= 1'b1;
            else if (free_now && rbank == 1'(b)) bank_full[b] <= 1'b0;
         end
      end
   end

   // a new error in the same cycle as err_clr keeps the flag set
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         overflow  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (ovf_ev)       overflow <= 1'b1;
         else if (err_clr) overflow <= 1'b0;
         if (err_ev)       frame_err <= 1'b1;
         else if (err_clr) frame_err <= 1'b0;
      end
   end

   // read side
   rstate_t         rstate, rstate_nx;
   logic [AB:0]     rcnt;
   logic [AB-1:0]   ridx;
   logic [AB:0]     raddr;
   logic [2:0]      occ;
   logic            issue, pop, room;
   logic            rd_pend, rd_sop, rd_eop;
   logic [CCW-1:0]  rd_cc;
   logic [2*DW-1:0] ram_q;
   beat_t           head, spare, push_beat;
   logic [1:0]      scnt;

   assign pop      = (scnt != 2'd0) && out_ready;
   assign free_now = pop && head.eop;
   assign occ      = {1'b0, scnt} + {2'b00, rd_pend} - {2'b00, pop};
   assign room     = occ < 3'd2;
   assign ridx     = rcnt[AB-1:0];
   assign raddr    = {rbank, ridx ^ MSB_FLIP};

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) rstate <= R_IDLE;
      else           rstate <= rstate_nx;
   end

   always_comb begin
      rstate_nx = rstate;
      case (rstate)
         R_IDLE:  if (bank_full[rbank]) rstate_nx = R_DRAIN;
         R_DRAIN: if (free_now)         rstate_nx = R_IDLE;
         default: rstate_nx = R_IDLE;
      endcase
   end

   // the first read goes out straight from idle so data arrives two cycles after eop
   always_comb begin
      issue = 1'b0;
      case (rstate)
         R_IDLE:  issue = room && bank_full[rbank];
         R_DRAIN: issue = room && !rcnt[AB];
         default: issue = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         rbank   <= 1'b0;
         rcnt    <= '0;
         rd_pend <= 1'b0;
         rd_sop  <= 1'b0;
         rd_eop  <= 1'b0;
         rd_cc   <= '0;
      end else begin
         if (free_now) begin
            rcnt  <= '0;
            rbank <= ~rbank;
         end else if (issue) begin
            rcnt <= rcnt + 1'b1;
         end
         rd_pend <= issue;
         if (issue) begin
            rd_sop <= (ridx == '0);
            rd_eop <= (ridx == LAST_BIN);
            rd_cc  <= bank_cc[rbank];
         end
      end
   end

   prach_fft_shift_bank_ram #(
      .DEPTH (2 * N_FFT),
      .AW    (AB + 1),
      .W     (2 * DW)
   ) u_ram (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata ({in_i, in_q}),
      .re    (issue),
      .raddr (raddr),
      .rdata (ram_q)
   );

   always_comb begin
      push_beat     = '0;
      push_beat.sop = rd_sop;
      push_beat.eop = rd_eop;
      push_beat.cc  = rd_cc;
      push_beat.i   = ram_q[2*DW-1:DW];
      push_beat.q   = ram_q[DW-1:0];
   end

   // two-entry skid: head drives the outputs, spare absorbs the in-flight read
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         head  <= '0;
         spare <= '0;
         scnt  <= 2'd0;
      end else begin
         case ({rd_pend, pop})
            2'b10: begin
               if (scnt == 2'd0) head  <= push_beat;
               else              spare <= push_beat;
               scnt <= scnt + 2'd1;
            end
            2'b01: begin
               if (scnt == 2'd2) head <= spare;
               scnt <= scnt - 2'd1;
            end
            2'b11: begin
               if (scnt == 2'd1) begin
                  head <= push_beat;
               end else begin
                  head  <= spare;
                  spare <= push_beat;
               end
            end
            default: ;
         endcase
      end
   end

   assign out_valid = (scnt != 2'd0);
   assign out_sop   = head.sop;
   assign out_eop   = head.eop;
   assign out_i     = head.i;
   assign out_q     = head.q;
   assign out_cc    = head.cc;

endmodule

// File: tb/tb_prach_fft_shift_reorder.sv
// Bench for prach_fft_shift_reorder at N_FFT=16: random and ramp frames
// compared against a queue model of the FFT-shift ordering.
module tb_prach_fft_shift_reorder;

   localparam int N   = 16;
   localparam int H   = N / 2;
   localparam int DW  = 16;
   localparam int CCW = 3;

   logic                 clk = 1'b0;
   logic                 areset_n = 1'b0;
   logic                 in_valid, in_sop, in_eop, out_ready, err_clr;
   logic signed [DW-1:0] in_i, in_q;
   logic [CCW-1:0]       in_cc;
   logic                 out_valid, out_sop, out_eop, overflow, frame_err;
   logic signed [DW-1:0] out_i, out_q;
   logic [CCW-1:0]       out_cc;

   always #5 clk = ~clk;

   prach_fft_shift_reorder #(.N_FFT(N), .DW(DW), .CCW(CCW)) dut (
      .clk(clk), .areset_n(areset_n),
      .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
      .in_i(in_i), .in_q(in_q), .in_cc(in_cc),
      .out_ready(out_ready), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
      .out_i(out_i), .out_q(out_q), .out_cc(out_cc),
      .err_clr(err_clr), .overflow(overflow), .frame_err(frame_err)
   );

   typedef struct packed {
      logic           sop;
      logic           eop;
      logic [CCW-1:0] cc;
      logic [DW-1:0]  i;
      logic [DW-1:0]  q;
   } beat_t;

   beat_t         exp_q[$];
   beat_t         got_q[$];
   beat_t         cur_beat, prev_beat;
   logic          prev_stall = 1'b0;
   int            stall_viol = 0;
   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] fr_i [N];
   logic [DW-1:0] fr_q [N];

   assign cur_beat = {out_sop, out_eop, out_cc, out_i, out_q};

   // record every accepted beat; count any change of a stalled beat
   always @(negedge clk) begin
      if (!areset_n) begin
         prev_stall <= 1'b0;
      end else begin
         if (prev_stall && (!out_valid || cur_beat !== prev_beat)) stall_viol <= stall_viol + 1;
         if (out_valid && out_ready) got_q.push_back(cur_beat);
         prev_stall <= out_valid && !out_ready;
         prev_beat  <= cur_beat;
      end
   end

   // reference: output position k carries input bin (k + N/2) mod N
   function automatic void expect_frame(input logic [CCW-1:0] cc);
      for (int k = 0; k < N; k++) begin
         int src = (k + H) % N;
         exp_q.push_back({k == 0, k == N - 1, cc, fr_i[src], fr_q[src]});
      end
   endfunction

   task automatic drive(input logic v, input logic s, input logic e,
                        input logic [DW-1:0] di, input logic [DW-1:0] dq, input logic [CCW-1:0] cc);
      in_valid = v; in_sop = s; in_eop = e; in_i = di; in_q = dq; in_cc = cc;
      @(posedge clk); #1;
   endtask

   task automatic idle_in();
      in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
   endtask

   task automatic cycles(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic fill_frame(input bit ramp);
      for (int b = 0; b < N; b++) begin
         if (ramp) begin
            fr_i[b] = DW'(b);
            fr_q[b] = -DW'(b);
         end else begin
            fr_i[b] = DW'($urandom);
            fr_q[b] = DW'($urandom);
         end
      end
   endtask

   task automatic send_frame(input logic [CCW-1:0] cc, input bit keep);
      if (keep) expect_frame(cc);
      for (int b = 0; b < N; b++)
         drive(1'b1, b == 0, b == N - 1, fr_i[b], fr_q[b], (b == 0) ? cc : CCW'($urandom));
      idle_in();
   endtask

   task automatic wait_out(input int n, input int budget);
      int cyc = 0;
      while (got_q.size() < n && cyc < budget) begin @(posedge clk); #1; cyc++; end
   endtask

   task automatic pulse_clr();
      err_clr = 1'b1; cycles(1); err_clr = 1'b0;
   endtask

   task automatic test_reset();
      idle_in(); in_i = '0; in_q = '0; in_cc = '0; out_ready = 1'b1; err_clr = 1'b0;
      areset_n = 1'b0;
      cycles(3);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      checks++; if (out_sop !== 1'b0)   begin errors++; $display("FAIL reset_sop: got %b want 0", out_sop); end
      checks++; if (out_eop !== 1'b0)   begin errors++; $display("FAIL reset_eop: got %b want 0", out_eop); end
      checks++; if (out_i !== '0)       begin errors++; $display("FAIL reset_i: got %h want 0", out_i); end
      checks++; if (out_q !== '0)       begin errors++; $display("FAIL reset_q: got %h want 0", out_q); end
      checks++; if (out_cc !== '0)      begin errors++; $display("FAIL reset_cc: got %h want 0", out_cc); end
      checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
      areset_n = 1'b1;
      cycles(2);
   endtask

   task automatic test_ramp_latency();
      out_ready = 1'b1;
      fill_frame(1'b1);
      send_frame(3'd6, 1'b1);
      cycles(1);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_eop_plus1: valid got %b want 0", out_valid); end
      cycles(1);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lat_eop_plus2: valid got %b want 1", out_valid); end
      checks++; if (out_sop !== 1'b1 || out_i !== DW'(H)) begin
         errors++; $display("FAIL lat_first_beat: sop %b i %0d, want sop 1 i %0d", out_sop, out_i, H);
      end
      wait_out(N, 100);
      cycles(4);
      checks++;
      if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL ramp_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int k = 0; k < exp_q.size(); k++) begin
         checks++;
         if (k >= got_q.size()) begin errors++; $display("FAIL ramp_beat%0d: missing, want %h", k, exp_q[k]); end
         else if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL ramp_beat%0d: got %h want %h", k, got_q[k], exp_q[k]); end
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      fill_frame(1'b0); send_frame(3'd3, 1'b1);
      fill_frame(1'b0); send_frame(3'd5, 1'b1);
      wait_out(2 * N, 200);
      cycles(4);
      checks++;
      if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int k = 0; k < exp_q.size(); k++) begin
         checks++;
         if (k >= got_q.size()) begin errors++; $display("FAIL b2b_beat%0d: missing, want %h", k, exp_q[k]); end
         else if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL b2b_beat%0d: got %h want %h", k, got_q[k], exp_q[k]); end
      end
      checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL b2b_overflow: got %b want 0", overflow); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL b2b_frame_err: got %b want 0", frame_err); end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_stall();
      int viol0 = stall_viol;
      fill_frame(1'b0);
      fork
         send_frame(CCW'($urandom), 1'b1);
         begin
            int cyc = 0;
            while (got_q.size() < N && cyc < 400) begin
               out_ready = 1'($urandom_range(0, 1));
               @(posedge clk); #1; cyc++;
            end
            out_ready = 1'b1;
         end
      join
      cycles(6);
      checks++; if (stall_viol != viol0) begin errors++; $display("FAIL stall_stable: %0d changes while stalled, want 0", stall_viol - viol0); end
      checks++;
      if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL stall_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int k = 0; k < exp_q.size(); k++) begin
         checks++;
         if (k >= got_q.size()) begin errors++; $display("FAIL stall_beat%0d: missing, want %h", k, exp_q[k]); end
         else if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL stall_beat%0d: got %h want %h", k, got_q[k], exp_q[k]); end
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_overflow();
      out_ready = 1'b0;
      fill_frame(1'b0); send_frame(3'd1, 1'b1);
      fill_frame(1'b0); send_frame(3'd2, 1'b1);
      fill_frame(1'b0); send_frame(3'd4, 1'b0);
      cycles(3);
      checks++; if (overflow !== 1'b1)  begin errors++; $display("FAIL ovf_set: got %b want 1", overflow); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ovf_frame_err: got %b want 0", frame_err); end
      out_ready = 1'b1;
      wait_out(2 * N, 300);
      cycles(N + 10);
      checks++;
      if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL ovf_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int k = 0; k < exp_q.size(); k++) begin
         checks++;
         if (k >= got_q.size()) begin errors++; $display("FAIL ovf_beat%0d: missing, want %h", k, exp_q[k]); end
         else if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL ovf_beat%0d: got %h want %h", k, got_q[k], exp_q[k]); end
      end
      got_q.delete(); exp_q.delete();
      pulse_clr();
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", overflow); end
   endtask

   task automatic test_malformed();
      out_ready = 1'b1;
      fill_frame(1'b0);
      for (int b = 0; b < N; b++) drive(1'b1, b == 0, 1'b0, fr_i[b], fr_q[b], 3'd1);
      idle_in(); cycles(2);
      checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL mal_no_eop: got %b want 1", frame_err); end
      pulse_clr();
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL mal_clear1: got %b want 0", frame_err); end
      for (int b = 0; b < 10; b++) drive(1'b1, b == 0, b == 9, fr_i[b], fr_q[b], 3'd2);
      idle_in(); cycles(1);
      checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL mal_early_eop: got %b want 1", frame_err); end
      err_clr = 1'b1;
      drive(1'b1, 1'b0, 1'b0, fr_i[0], fr_q[0], 3'd0);
      err_clr = 1'b0; idle_in();
      checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL mal_clr_vs_err: got %b want 1", frame_err); end
      cycles(N + 10);
      checks++; if (got_q.size() != 0) begin errors++; $display("FAIL mal_no_output: got %0d beats want 0", got_q.size()); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mal_overflow: got %b want 0", overflow); end
      pulse_clr();
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL mal_clear2: got %b want 0", frame_err); end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_sop_restart();
      out_ready = 1'b1;
      fill_frame(1'b0);
      for (int b = 0; b < 5; b++) drive(1'b1, b == 0, 1'b0, fr_i[b], fr_q[b], 3'd1);
      fill_frame(1'b0);
      send_frame(3'd2, 1'b1);
      cycles(1);
      checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL restart_err: got %b want 1", frame_err); end
      wait_out(N, 100);
      cycles(4);
      checks++;
      if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL restart_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int k = 0; k < exp_q.size(); k++) begin
         checks++;
         if (k >= got_q.size()) begin errors++; $display("FAIL restart_beat%0d: missing, want %h", k, exp_q[k]); end
         else if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL restart_beat%0d: got %h want %h", k, got_q[k], exp_q[k]); end
      end
      got_q.delete(); exp_q.delete();
      pulse_clr();
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL restart_clear: got %b want 0", frame_err); end
   endtask

   task automatic test_reset_mid_drain();
      out_ready = 1'b0;
      fill_frame(1'b0); send_frame(3'd1, 1'b0);
      fill_frame(1'b0); send_frame(3'd2, 1'b0);
      out_ready = 1'b1;
      cycles(4);
      areset_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
      checks++; if ({out_sop, out_eop, out_cc, out_i, out_q} !== '0) begin
         errors++; $display("FAIL mid_rst_data: got %h want 0", {out_sop, out_eop, out_cc, out_i, out_q});
      end
      got_q.delete(); exp_q.delete();
      cycles(2);
      areset_n = 1'b1;
      cycles(N + 20);
      checks++; if (got_q.size() != 0) begin errors++; $display("FAIL mid_rst_stale: got %0d beats want 0", got_q.size()); end
      fill_frame(1'b0);
      send_frame(3'd7, 1'b1);
      wait_out(N, 100);
      cycles(4);
      checks++;
      if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL mid_rst_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int k = 0; k < exp_q.size(); k++) begin
         checks++;
         if (k >= got_q.size()) begin errors++; $display("FAIL mid_rst_beat%0d: missing, want %h", k, exp_q[k]); end
         else if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL mid_rst_beat%0d: got %h want %h", k, got_q[k], exp_q[k]); end
      end
      got_q.delete(); exp_q.delete();
   endtask

   initial begin
      test_reset();
      test_ramp_latency();
      test_back_to_back();
      test_stall();
      test_overflow();
      test_malformed();
      test_sop_restart();
      test_reset_mid_drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
      $fatal(1, "watchdog expired");
   end

endmodule
